// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: one request in flight, fixed latency, held response.
// Optional DMEM_BYTE_OP_EN enables byte-lane loads and stores.
package data_mem_ctrl_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic single_cycle = (latency_p == 1);

    state_e                  state;
    logic [3:0]              count;
    logic [addr_width_p-1:0] req_idx;
    logic [31:0]             req_data;
    logic                    req_wen;
    logic                    hold_off;
    logic [31:0]             read_data;
    logic [31:0]             mem [2**addr_width_p];

    logic                    accept;
    logic                    commit;
    logic [addr_width_p-1:0] op_idx;
    logic [31:0]             op_data;
    logic                    op_wen;
    logic [31:0]             op_word;
    logic [31:0]             load_value;
    logic                    unused_bits;

`ifdef DMEM_BYTE_OP_EN
    logic       req_byte;
    logic [1:0] req_lane;
    logic       op_byte;
    logic [1:0] op_lane;

    assign op_byte     = (state == IDLE) ? to_mem_i.byte_not_word : req_byte;
    assign op_lane     = (state == IDLE) ? addr_i[1:0] : req_lane;
    assign load_value  = op_byte ? {24'd0, op_word[{op_lane, 3'b000} +: 8]} : op_word;
    assign unused_bits = ^addr_i[31:2+addr_width_p];
`else
    assign load_value  = op_word;
    assign unused_bits = ^{addr_i[31:2+addr_width_p], addr_i[1:0], to_mem_i.byte_not_word};
`endif

    // The one-cycle build performs the array access on the accept edge itself,
    // so the operand muxes select live inputs in IDLE and latched ones otherwise.
    assign accept  = (state == IDLE) && to_mem_i.valid && !reset && !hold_off;
    assign commit  = (accept && single_cycle) || (state == BUSY && count == 4'd1 && !reset);
    assign op_idx  = (state == IDLE) ? addr_i[2 +: addr_width_p] : req_idx;
    assign op_data = (state == IDLE) ? to_mem_i.write_data : req_data;
    assign op_wen  = (state == IDLE) ? to_mem_i.wen : req_wen;
    assign op_word = mem[op_idx];

    always_comb begin
        from_mem_o           = '0;
        from_mem_o.read_data = read_data;
        from_mem_o.valid     = (state == RESP);
        from_mem_o.yumi      = accept;
        busy_o               = (state != IDLE);
    end

    // Array contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (commit && op_wen) begin
`ifdef DMEM_BYTE_OP_EN
            if (op_byte)
                mem[op_idx][{op_lane, 3'b000} +: 8] <= op_data[7:0];
            else
                mem[op_idx] <= op_data;
`else
            mem[op_idx] <= op_data;
`endif
        end
    end

    // hold_off blocks an accept in the first IDLE cycle after a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            req_idx   <= '0;
            req_data  <= 32'd0;
            req_wen   <= 1'b0;
            hold_off  <= 1'b0;
            read_data <= 32'd0;
`ifdef DMEM_BYTE_OP_EN
            req_byte  <= 1'b0;
            req_lane  <= 2'd0;
`endif
        end else begin
            hold_off <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_idx  <= addr_i[2 +: addr_width_p];
                        req_data <= to_mem_i.write_data;
                        req_wen  <= to_mem_i.wen;
`ifdef DMEM_BYTE_OP_EN
                        req_byte <= to_mem_i.byte_not_word;
                        req_lane <= addr_i[1:0];
`endif
                        count    <= 4'(latency_p - 1);
                        state    <= single_cycle ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    if (to_mem_i.yumi) begin
                        state    <= IDLE;
                        hold_off <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit)
                read_data <= op_wen ? 32'd0 : load_value;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: latency-2 instance for most checks, latency-1 instance
// for back-to-back spacing. Byte expectations follow DMEM_BYTE_OP_EN.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     tm, tm1;
    logic [31:0] addr, addr1;
    mem_out_s    fm, fm1;
    logic        busy, busy1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) dut (
        .clk(clk), .reset(reset), .to_mem_i(tm), .addr_i(addr),
        .from_mem_o(fm), .busy_o(busy)
    );

    data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) dut1 (
        .clk(clk), .reset(reset), .to_mem_i(tm1), .addr_i(addr1),
        .from_mem_o(fm1), .busy_o(busy1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic wen, input logic bnw, input logic [31:0] a, input logic [31:0] d);
        tm.valid         = 1'b1;
        tm.wen           = wen;
        tm.byte_not_word = bnw;
        tm.write_data    = d;
        addr             = a;
        #1;
    endtask

    // Full transaction on the latency-2 instance; leaves the DUT ready to accept.
    task automatic txn(input logic wen, input logic bnw, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input string tag);
        apply_stimulus(wen, bnw, a, d);
        check_output({tag, ".accept"}, 32'(fm.yumi), 32'd1);
        tick();
        tm.valid = 1'b0;
        check_output({tag, ".busy"}, {30'd0, busy, fm.valid}, {30'd0, 1'b1, 1'b0});
        tick();
        check_output({tag, ".valid"}, 32'(fm.valid), 32'd1);
        check_output({tag, ".rdata"}, fm.read_data, exp);
        tm.yumi = 1'b1;
        tick();
        tm.yumi = 1'b0;
        check_output({tag, ".idle"}, {30'd0, busy, fm.valid}, 32'd0);
        tick();
    endtask

    initial begin
        tm    = '0;
        tm1   = '0;
        addr  = 32'd0;
        addr1 = 32'd0;
        reset = 1'b1;
        tm.valid = 1'b1;
        tick();
        tick();
        check_output("reset.yumi", 32'(fm.yumi), 32'd0);
        reset = 1'b0;
        tm.valid = 1'b0;
        #1;
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.valid", 32'(fm.valid), 32'd0);
        check_output("reset.rdata", fm.read_data, 32'd0);

        $display("[TB] store/load round trip");
        txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, "st10");
        txn(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, "ld10");

        $display("[TB] held response and delayed re-accept");
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'd0);
        check_output("hold.accept", 32'(fm.yumi), 32'd1);
        tick();
        tm.valid = 1'b0;
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_output("hold.valid", 32'(fm.valid), 32'd1);
            check_output("hold.rdata", fm.read_data, 32'hDEADBEEF);
            check_output("hold.noaccept", 32'(fm.yumi), 32'd0);
            tick();
        end
        tm.yumi = 1'b1;
        #1;
        check_output("hold.resp_noaccept", 32'(fm.yumi), 32'd0);
        tick();
        tm.yumi = 1'b0;
        #1;
        check_output("hold.idle", 32'(busy), 32'd0);
        check_output("hold.first_idle_noaccept", 32'(fm.yumi), 32'd0);
        tick();
        check_output("hold.reaccept", 32'(fm.yumi), 32'd1);
        tick();
        tm.valid = 1'b0;
        tick();
        check_output("hold2.valid", 32'(fm.valid), 32'd1);
        check_output("hold2.rdata", fm.read_data, 32'hDEADBEEF);
        tm.yumi = 1'b1;
        tick();
        tm.yumi = 1'b0;
        tick();

        $display("[TB] address wrap");
        txn(1'b1, 1'b0, 32'h1004, 32'h1, 32'd0, "st1004");
        txn(1'b0, 1'b0, 32'h4, 32'd0, 32'h1, "ld4wrap");

        $display("[TB] reset aborts in-flight store");
        txn(1'b1, 1'b0, 32'h20, 32'h55, 32'd0, "st20");
        apply_stimulus(1'b1, 1'b0, 32'h20, 32'hAA);
        check_output("abort.accept", 32'(fm.yumi), 32'd1);
        tick();
        tm.valid = 1'b0;
        reset = 1'b1;
        tick();
        check_output("abort.busy", 32'(busy), 32'd0);
        check_output("abort.valid", 32'(fm.valid), 32'd0);
        check_output("abort.rdata", fm.read_data, 32'd0);
        reset = 1'b0;
        txn(1'b0, 1'b0, 32'h20, 32'd0, 32'h55, "ld20");

        $display("[TB] byte lane access");
        txn(1'b1, 1'b0, 32'h40, 32'h11223344, 32'd0, "st40");
        txn(1'b1, 1'b1, 32'h41, 32'h000000FF, 32'd0, "stb41");
`ifdef DMEM_BYTE_OP_EN
        txn(1'b0, 1'b0, 32'h40, 32'd0, 32'h1122FF44, "ld40");
        txn(1'b0, 1'b1, 32'h43, 32'd0, 32'h00000011, "ldb43");
`else
        txn(1'b0, 1'b0, 32'h40, 32'd0, 32'h000000FF, "ld40");
        txn(1'b0, 1'b1, 32'h43, 32'd0, 32'h000000FF, "ldb43");
`endif

        $display("[TB] latency 1 back-to-back");
        tm1.valid      = 1'b1;
        tm1.wen        = 1'b1;
        tm1.write_data = 32'h12345678;
        addr1          = 32'h8;
        #1;
        check_output("l1.st_accept", 32'(fm1.yumi), 32'd1);
        tick();
        check_output("l1.st_valid", 32'(fm1.valid), 32'd1);
        check_output("l1.st_rdata", fm1.read_data, 32'd0);
        tm1.wen  = 1'b0;
        tm1.yumi = 1'b1;
        #1;
        check_output("l1.st_resp_noaccept", 32'(fm1.yumi), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output("l1.gap_idle", 32'(busy1), 32'd0);
            check_output("l1.gap_noaccept", 32'(fm1.yumi), 32'd0);
            tick();
            check_output("l1.ld_accept", 32'(fm1.yumi), 32'd1);
            tick();
            check_output("l1.ld_valid", 32'(fm1.valid), 32'd1);
            check_output("l1.ld_rdata", fm1.read_data, 32'h12345678);
        end
        tm1.valid = 1'b0;
        tick();
        tm1.yumi = 1'b0;
        check_output("l1.final_idle", 32'(busy1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
